// File: rtl/cam_rst_seq.sv
// Camera power/reset sequencer: resets the PLL, waits for a filtered lock,
// then walks the image sensor out of power-down and reset before releasing
// the downstream system reset. Lock loss or restart resequences from PLL_RST.
//
// Handshake: restart is a single-cycle request with no ready/ack; it is
// acted on at the edge where it is sampled high and needs no hold.
module cam_rst_seq #(
  parameter int unsigned PLL_RST_LEN  = 4,
  parameter int unsigned LOCK_FILT    = 8,
  parameter int unsigned LOCK_TIMEOUT = 1000,
  parameter int unsigned PWDN_DLY     = 16,
  parameter int unsigned RST_DLY      = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lock,
  input  logic       restart,
  output logic       pll_reset,
  output logic       sys_rst,
  output logic       cam_pwdn,
  output logic       cam_rst_n,
  output logic       ready,
  output logic [3:0] retry_cnt,
  output logic [7:0] loss_cnt,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    S_PLL_RST   = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_PWR_UP    = 3'd2,
    S_CAM_RST   = 3'd3,
    S_RUN       = 3'd4
  } state_t;

  // Terminal dwell values: a state lasting N cycles exits when dwell == N-1.
  localparam logic [15:0] PLL_END  = 16'(PLL_RST_LEN - 1);
  localparam logic [15:0] FILT_END = 16'(LOCK_FILT - 1);
  localparam logic [15:0] TO_END   = 16'(LOCK_TIMEOUT - 1);
  localparam logic [15:0] PWDN_END = 16'(PWDN_DLY - 1);
  localparam logic [15:0] RST_END  = 16'(RST_DLY - 1);

  state_t      state;
  state_t      state_nxt;
  logic [15:0] dwell;
  logic [15:0] filt;
  logic        sync_q1;
  logic        lock_s;
  logic        retry_inc;
  logic        loss_inc;
  logic        enter;
  logic        pll_reset_nxt;
  logic        sys_rst_nxt;
  logic        cam_pwdn_nxt;
  logic        cam_rst_n_nxt;
  logic        ready_nxt;

  assign state_dbg = state;

  // Two-flop synchronizer for the asynchronous PLL lock.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q1 <= 1'b0;
      lock_s  <= 1'b0;
    end else begin
      sync_q1 <= lock;
      lock_s  <= sync_q1;
    end
  end

  // Next-state logic; restart overrides everything except rst.
  always_comb begin
    state_nxt = state;
    retry_inc = 1'b0;
    loss_inc  = 1'b0;
    case (state)
      S_PLL_RST: begin
        if (dwell == PLL_END) state_nxt = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        // Filter completion wins over a coincident timeout.
        if (lock_s && (filt == FILT_END)) begin
          state_nxt = S_PWR_UP;
        end else if (dwell == TO_END) begin
          state_nxt = S_PLL_RST;
          retry_inc = 1'b1;
        end
      end
      S_PWR_UP: begin
        if (!lock_s) begin
          state_nxt = S_PLL_RST;
          loss_inc  = 1'b1;
        end else if (dwell == PWDN_END) begin
          state_nxt = S_CAM_RST;
        end
      end
      S_CAM_RST: begin
        if (!lock_s) begin
          state_nxt = S_PLL_RST;
          loss_inc  = 1'b1;
        end else if (dwell == RST_END) begin
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (!lock_s) begin
          state_nxt = S_PLL_RST;
          loss_inc  = 1'b1;
        end
      end
      default: state_nxt = S_PLL_RST;
    endcase
    if (restart) begin
      state_nxt = S_PLL_RST;
      retry_inc = 1'b0;
      loss_inc  = 1'b0;
    end
  end

  // A restart re-enters PLL_RST even when already there.
  assign enter = restart || (state_nxt != state);

  // Output decode from the next state so outputs change with the state.
  always_comb begin
    pll_reset_nxt = (state_nxt == S_PLL_RST);
    cam_pwdn_nxt  = (state_nxt == S_PLL_RST) || (state_nxt == S_WAIT_LOCK);
    cam_rst_n_nxt = (state_nxt == S_CAM_RST) || (state_nxt == S_RUN);
    sys_rst_nxt   = (state_nxt != S_RUN);
    ready_nxt     = (state_nxt == S_RUN);
  end

  // State, dwell/filter counters, event counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_PLL_RST;
      dwell     <= '0;
      filt      <= '0;
      retry_cnt <= '0;
      loss_cnt  <= '0;
      pll_reset <= 1'b1;
      sys_rst   <= 1'b1;
      cam_pwdn  <= 1'b1;
      cam_rst_n <= 1'b0;
      ready     <= 1'b0;
    end else begin
      state <= state_nxt;
      // RUN has no timed exit, so hold the dwell at full scale there.
      if (enter) dwell <= '0;
      else if (dwell != 16'hffff) dwell <= dwell + 16'd1;
      if (enter || !lock_s || (state != S_WAIT_LOCK)) filt <= '0;
      else filt <= filt + 16'd1;
      if (retry_inc && (retry_cnt != 4'hf)) retry_cnt <= retry_cnt + 4'd1;
      if (loss_inc && (loss_cnt != 8'hff)) loss_cnt <= loss_cnt + 8'd1;
      pll_reset <= pll_reset_nxt;
      sys_rst   <= sys_rst_nxt;
      cam_pwdn  <= cam_pwdn_nxt;
      cam_rst_n <= cam_rst_n_nxt;
      ready     <= ready_nxt;
    end
  end

endmodule

// File: tb/tb_cam_rst_seq.sv
// Directed bench for cam_rst_seq at default parameters. Each step pushes the
// expected output vector, advances the clock, then pops and compares.
module tb_cam_rst_seq;

  localparam int W = 20;
  localparam logic [2:0] ST_PLL  = 3'd0;
  localparam logic [2:0] ST_WAIT = 3'd1;
  localparam logic [2:0] ST_PWR  = 3'd2;
  localparam logic [2:0] ST_CAM  = 3'd3;
  localparam logic [2:0] ST_RUN  = 3'd4;

  logic       clk = 1'b0;
  logic       rst;
  logic       lock;
  logic       restart;
  logic       pll_reset;
  logic       sys_rst;
  logic       cam_pwdn;
  logic       cam_rst_n;
  logic       ready;
  logic [3:0] retry_cnt;
  logic [7:0] loss_cnt;
  logic [2:0] state_dbg;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // Clock and DUT
  always #5 clk = ~clk;

  cam_rst_seq dut (
    .clk       (clk),
    .rst       (rst),
    .lock      (lock),
    .restart   (restart),
    .pll_reset (pll_reset),
    .sys_rst   (sys_rst),
    .cam_pwdn  (cam_pwdn),
    .cam_rst_n (cam_rst_n),
    .ready     (ready),
    .retry_cnt (retry_cnt),
    .loss_cnt  (loss_cnt),
    .state_dbg (state_dbg)
  );

  // Expected vector: state, the five pins decoded from the state, counters.
  function automatic logic [W-1:0] exp_vec(input logic [2:0] st,
                                           input logic [3:0] rc,
                                           input logic [7:0] lc);
    logic p, w, n, s, r;
    p = (st == ST_PLL);
    w = (st == ST_PLL) || (st == ST_WAIT);
    n = (st == ST_CAM) || (st == ST_RUN);
    s = (st != ST_RUN);
    r = (st == ST_RUN);
    return {st, p, w, n, s, r, rc, lc};
  endfunction

  // Advance n clocks and settle 1 time unit past the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard step: queue expectation, run n clocks, pop and compare.
  task automatic step(input int n, input logic [W-1:0] e, input string tag);
    logic [W-1:0] got;
    logic [W-1:0] want;
    exp_q.push_back(e);
    tick(n);
    got = {state_dbg, pll_reset, cam_pwdn, cam_rst_n, sys_rst, ready,
           retry_cnt, loss_cnt};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s scoreboard empty got=%h", tag, got);
    end else begin
      want = exp_q.pop_front();
      assert (got === want) else begin
        errors++;
        $error("FAIL %s got=%h exp=%h", tag, got, want);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    lock = 1'b1;
    restart = 1'b0;

    // Reset state
    step(3, exp_vec(ST_PLL, 4'd0, 8'd0), "reset");
    rst = 1'b0;

    // Nominal bring-up with lock held high
    step(3,  exp_vec(ST_PLL,  4'd0, 8'd0), "pll_rst_c3");
    step(1,  exp_vec(ST_WAIT, 4'd0, 8'd0), "wait_c4");
    step(7,  exp_vec(ST_WAIT, 4'd0, 8'd0), "wait_c11");
    step(1,  exp_vec(ST_PWR,  4'd0, 8'd0), "pwr_c12");
    step(15, exp_vec(ST_PWR,  4'd0, 8'd0), "pwr_c27");
    step(1,  exp_vec(ST_CAM,  4'd0, 8'd0), "cam_c28");
    step(31, exp_vec(ST_CAM,  4'd0, 8'd0), "cam_c59");
    step(1,  exp_vec(ST_RUN,  4'd0, 8'd0), "run_c60");
    step(20, exp_vec(ST_RUN,  4'd0, 8'd0), "run_hold");

    // Lock drop of 3 cycles in RUN
    lock = 1'b0;
    step(2, exp_vec(ST_RUN, 4'd0, 8'd0), "loss_sync_delay");
    step(1, exp_vec(ST_PLL, 4'd0, 8'd1), "loss_to_pll");
    lock = 1'b1;
    step(4,  exp_vec(ST_WAIT, 4'd0, 8'd1), "reseq_wait");
    step(8,  exp_vec(ST_PWR,  4'd0, 8'd1), "reseq_pwr");
    step(48, exp_vec(ST_RUN,  4'd0, 8'd1), "reseq_run");

    // Plain restart from RUN, then restart coincident with loss in CAM_RST
    restart = 1'b1;
    step(1, exp_vec(ST_PLL, 4'd0, 8'd1), "restart_run");
    restart = 1'b0;
    step(28, exp_vec(ST_CAM, 4'd0, 8'd1), "restart_cam");
    lock = 1'b0;
    step(2, exp_vec(ST_CAM, 4'd0, 8'd1), "cam_pre_loss");
    restart = 1'b1;
    step(1, exp_vec(ST_PLL, 4'd0, 8'd1), "restart_beats_loss");
    restart = 1'b0;

    // Lock 7 high / 1 low never satisfies the filter; timeout after 1000
    for (int i = 0; i < 1003; i++) begin
      lock = ((i % 8) != 7);
      tick(1);
    end
    step(0, exp_vec(ST_WAIT, 4'd0, 8'd1), "toggle_wait_end");
    lock = 1'b0;
    step(1, exp_vec(ST_PLL, 4'd1, 8'd1), "toggle_timeout");

    // rst in the middle of PWR_UP clears everything
    lock = 1'b1;
    step(12, exp_vec(ST_PWR, 4'd1, 8'd1), "pre_rst_pwr");
    step(10, exp_vec(ST_PWR, 4'd1, 8'd1), "pwr_mid");
    rst = 1'b1;
    step(1, exp_vec(ST_PLL, 4'd0, 8'd0), "mid_rst");
    lock = 1'b0;
    step(2, exp_vec(ST_PLL, 4'd0, 8'd0), "mid_rst_hold");
    rst = 1'b0;

    // Lock held low: periodic PLL resets, retry_cnt saturating at 15
    for (int k = 1; k <= 17; k++) begin
      step(3,   exp_vec(ST_PLL,  4'((k - 1 > 15) ? 15 : k - 1), 8'd0), "nolock_pll");
      step(1,   exp_vec(ST_WAIT, 4'((k - 1 > 15) ? 15 : k - 1), 8'd0), "nolock_wait");
      step(999, exp_vec(ST_WAIT, 4'((k - 1 > 15) ? 15 : k - 1), 8'd0), "nolock_wait_end");
      step(1,   exp_vec(ST_PLL,  4'((k > 15) ? 15 : k), 8'd0), "nolock_retry");
    end

    if (exp_q.size() != 0) begin
      errors++;
      $error("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
